// File: rtl/counter_scheduler.sv
// ============================================================================
// Module     : counter_scheduler
// Description: Two-requester round-robin scheduler in front of a shared 4-bit
//              up-counter. A granted requester gets one run that counts q from
//              0 up to its latched terminal count. A one-cycle done pulse ends
//              the run. Abort ends the run early without a done pulse.
// Config     : COUNTER_SCHEDULER_BACK_TO_BACK_EN - when defined, arbitration
//              is also active in DONE. A new run can then start with no idle
//              cycle in between.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module counter_scheduler (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0,
    input  logic       req1,
    input  logic [3:0] len0,
    input  logic [3:0] len1,
    input  logic       abort,
    output logic       gnt0,
    output logic       gnt1,
    output logic [3:0] q,
    output logic       owner,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q,   cnt_d;
    logic [3:0] limit_q, limit_d;
    logic       owner_q, owner_d;
    // Index of the last granted requester. It resets to 1 so that the first
    // contested grant after reset goes to requester 0.
    logic       last_q,  last_d;

    logic       arb_en;
    logic       winner;
    logic       grant;
    logic [3:0] win_len;

    // Arbitration window. Grants are held off while reset is asserted, so the
    // gnt outputs are forced low immediately.
`ifdef COUNTER_SCHEDULER_BACK_TO_BACK_EN
    assign arb_en = reset & ((state_q == S_IDLE) | (state_q == S_DONE));
`else
    assign arb_en = reset & (state_q == S_IDLE);
`endif

    // Round-robin pick. When both requesters ask, the one not granted last
    // wins. Otherwise the single requester wins.
    always_comb begin
        winner = 1'b0;
        if (req0 & req1) begin
            winner = ~last_q;
        end else begin
            winner = req1;
        end
    end

    assign grant   = arb_en & (req0 | req1);
    assign gnt0    = grant & ~winner;
    assign gnt1    = grant &  winner;
    assign win_len = winner ? len1 : len0;

    // Next-state logic for the run controller and its counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        limit_d = limit_q;
        owner_d = owner_q;
        last_d  = last_q;
        case (state_q)
            S_IDLE: begin
                if (grant) begin
                    state_d = S_RUN;
                    cnt_d   = 4'd0;
                    limit_d = win_len;
                    owner_d = winner;
                    last_d  = winner;
                end
            end
            S_RUN: begin
                // Abort takes priority over reaching the terminal count.
                if (abort) begin
                    state_d = S_IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q == limit_q) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_DONE: begin
                // grant can only be high here in the back-to-back build.
                if (grant) begin
                    state_d = S_RUN;
                    cnt_d   = 4'd0;
                    limit_d = win_len;
                    owner_d = winner;
                    last_d  = winner;
                end else begin
                    state_d = S_IDLE;
                    cnt_d   = 4'd0;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            limit_q <= 4'd0;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            limit_q <= limit_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

    assign q     = cnt_q;
    assign owner = owner_q;
    assign busy  = (state_q != S_IDLE);
    assign done  = (state_q == S_DONE);

endmodule

`default_nettype wire
